// File: rtl/mem_responder.sv
// Memory-side responder for the adding-machine bus. It serves rd_mem/wr_mem requests
// from an internal word array, adds programmable wait states, and has a preload port.
module mem_responder #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_mem,
  input  logic              wr_mem,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              mem_ready,
  output logic              mem_busy,
  output logic              mem_err,
  input  logic              pl_en,
  input  logic [ADDR_W-1:0] pl_adr,
  input  logic [DATA_W-1:0] pl_data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t state, state_nx;
  logic [3:0]        cnt;
  logic              lat_wr;
  logic [ADDR_W-1:0] lat_adr;
  logic [DATA_W-1:0] lat_data;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              err_set;
  logic              commit;
  logic              commit_wr;
  logic [ADDR_W-1:0] commit_adr;
  logic [DATA_W-1:0] commit_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  // With zero wait states the access commits straight from the live request inputs.
  always_comb begin
    state_nx    = state;
    accept      = 1'b0;
    err_set     = 1'b0;
    commit      = 1'b0;
    commit_wr   = lat_wr;
    commit_adr  = lat_adr;
    commit_data = lat_data;
    mem_we      = 1'b0;
    mem_wa      = pl_adr;
    mem_wd      = pl_data;
    case (state)
      S_IDLE: begin
        if (pl_en) begin
          mem_we = 1'b1;
        end else if (rd_mem && wr_mem) begin
          err_set = 1'b1;
        end else if (rd_mem || wr_mem) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_nx    = S_RESP;
            commit      = 1'b1;
            commit_wr   = wr_mem;
            commit_adr  = adr;
            commit_data = data_in;
          end else begin
            state_nx = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = S_RESP;
          commit   = 1'b1;
        end
      end
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (commit && commit_wr) begin
      mem_we = 1'b1;
      mem_wa = commit_adr;
      mem_wd = commit_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      data_out <= '0;
      mem_err  <= 1'b0;
      lat_wr   <= 1'b0;
      lat_adr  <= '0;
      lat_data <= '0;
    end else begin
      state   <= state_nx;
      mem_err <= err_set;
      if (accept) begin
        lat_wr   <= wr_mem;
        lat_adr  <= adr;
        lat_data <= data_in;
        cnt      <= CNT_INIT;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit && !commit_wr) data_out <= mem[commit_adr];
    end
  end

  // Array contents survive reset; reset only blocks writes in its own cycle.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem[mem_wa] <= mem_wd;
  end

  assign mem_ready = (state == S_RESP);
  assign mem_busy  = (state != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder; three instances (0, 1 and 3 wait
// states) share one stimulus bus and each scenario checks the instance it targets.
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       rd_mem, wr_mem, pl_en;
  logic [5:0] adr, pl_adr;
  logic [7:0] data_in, pl_data;

  logic [7:0] dout0, dout1, dout3;
  logic       rdy0, rdy1, rdy3, busy0, busy1, busy3, err0, err1, err3;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(6), .DATA_W(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .rd_mem(rd_mem), .wr_mem(wr_mem), .adr(adr),
    .data_in(data_in), .data_out(dout0), .mem_ready(rdy0), .mem_busy(busy0),
    .mem_err(err0), .pl_en(pl_en), .pl_adr(pl_adr), .pl_data(pl_data));

  mem_responder #(.ADDR_W(6), .DATA_W(8), .WAIT_STATES(1)) dut1 (
    .clk(clk), .reset(reset), .rd_mem(rd_mem), .wr_mem(wr_mem), .adr(adr),
    .data_in(data_in), .data_out(dout1), .mem_ready(rdy1), .mem_busy(busy1),
    .mem_err(err1), .pl_en(pl_en), .pl_adr(pl_adr), .pl_data(pl_data));

  mem_responder #(.ADDR_W(6), .DATA_W(8), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset), .rd_mem(rd_mem), .wr_mem(wr_mem), .adr(adr),
    .data_in(data_in), .data_out(dout3), .mem_ready(rdy3), .mem_busy(busy3),
    .mem_err(err3), .pl_en(pl_en), .pl_adr(pl_adr), .pl_data(pl_data));

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic preload(input logic [5:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_adr = a; pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step(2);
    total++;
    if ({dout0, rdy0, busy0, err0} !== 11'h0) $display("[TB] FAIL reset_ws0: got %h want 0", {dout0, rdy0, busy0, err0});
    else passed++;
    total++;
    if ({dout1, rdy1, busy1, err1} !== 11'h0) $display("[TB] FAIL reset_ws1: got %h want 0", {dout1, rdy1, busy1, err1});
    else passed++;
    total++;
    if ({dout3, rdy3, busy3, err3} !== 11'h0) $display("[TB] FAIL reset_ws3: got %h want 0", {dout3, rdy3, busy3, err3});
    else passed++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_read_ws1;
    rd_mem = 1'b1; adr = 6'd5;
    step();
    rd_mem = 1'b0;
    total++;
    if ({rdy1, busy1} !== 2'b01) $display("[TB] FAIL rd_wait: got rdy/busy %b want 01", {rdy1, busy1});
    else passed++;
    step();
    total++;
    if ({rdy1, busy1} !== 2'b11) $display("[TB] FAIL rd_resp: got rdy/busy %b want 11", {rdy1, busy1});
    else passed++;
    total++;
    if (dout1 !== 8'h4A) $display("[TB] FAIL rd_data: got %h want 4a", dout1);
    else passed++;
    step();
    total++;
    if ({rdy1, busy1} !== 2'b00) $display("[TB] FAIL rd_idle: got rdy/busy %b want 00", {rdy1, busy1});
    else passed++;
    step(4);
  endtask

  task automatic test_write_read;
    wr_mem = 1'b1; adr = 6'd63; data_in = 8'hC3;
    step();
    wr_mem = 1'b0;
    step();
    total++;
    if (rdy1 !== 1'b1) $display("[TB] FAIL wr_ready: got %b want 1", rdy1);
    else passed++;
    total++;
    if (dout1 !== 8'h4A) $display("[TB] FAIL wr_dout_hold: got %h want 4a", dout1);
    else passed++;
    step();
    rd_mem = 1'b1;
    step();
    rd_mem = 1'b0;
    step();
    total++;
    if ({rdy1, dout1} !== 9'h1C3) $display("[TB] FAIL raw_read: got rdy/data %h want 1c3", {rdy1, dout1});
    else passed++;
    step(4);
  endtask

  task automatic test_ws0;
    rd_mem = 1'b1; adr = 6'd0;
    step();
    rd_mem = 1'b0;
    total++;
    if ({rdy0, busy0} !== 2'b11) $display("[TB] FAIL ws0_resp: got rdy/busy %b want 11", {rdy0, busy0});
    else passed++;
    total++;
    if (dout0 !== 8'h11) $display("[TB] FAIL ws0_data: got %h want 11", dout0);
    else passed++;
    step();
    total++;
    if ({rdy0, busy0} !== 2'b00) $display("[TB] FAIL ws0_idle: got rdy/busy %b want 00", {rdy0, busy0});
    else passed++;
    step(4);
  endtask

  task automatic test_error;
    rd_mem = 1'b1; wr_mem = 1'b1; adr = 6'd2; data_in = 8'hEE;
    step();
    rd_mem = 1'b0; wr_mem = 1'b0;
    total++;
    if ({err1, busy1, rdy1} !== 3'b100) $display("[TB] FAIL err_pulse: got err/busy/rdy %b want 100", {err1, busy1, rdy1});
    else passed++;
    step();
    total++;
    if ({err1, busy1} !== 2'b00) $display("[TB] FAIL err_clear: got err/busy %b want 00", {err1, busy1});
    else passed++;
    rd_mem = 1'b1;
    step();
    rd_mem = 1'b0;
    step();
    total++;
    if ({rdy1, dout1} !== 9'h122) $display("[TB] FAIL err_no_write: got rdy/data %h want 122", {rdy1, dout1});
    else passed++;
    step(4);
  endtask

  task automatic test_reset_mid_access;
    int pulses = 0;
    wr_mem = 1'b1; adr = 6'd9; data_in = 8'hFF;
    step();
    wr_mem = 1'b0;
    step();
    total++;
    if ({rdy3, busy3} !== 2'b01) $display("[TB] FAIL mid_in_wait: got rdy/busy %b want 01", {rdy3, busy3});
    else passed++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if ({dout3, rdy3, busy3, err3} !== 11'h0) $display("[TB] FAIL mid_reset_outs: got %h want 0", {dout3, rdy3, busy3, err3});
    else passed++;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rdy3) pulses++;
    end
    total++;
    if (pulses != 0) $display("[TB] FAIL mid_no_ready: got %0d pulses want 0", pulses);
    else passed++;
    rd_mem = 1'b1;
    step();
    rd_mem = 1'b0;
    step(2);
    total++;
    if ({rdy3, busy3} !== 2'b01) $display("[TB] FAIL ws3_last_wait: got rdy/busy %b want 01", {rdy3, busy3});
    else passed++;
    step();
    total++;
    if ({rdy3, dout3} !== 9'h100) $display("[TB] FAIL ws3_discarded_write: got rdy/data %h want 100", {rdy3, dout3});
    else passed++;
    step(3);
  endtask

  // A held request repeats every 3 cycles with one wait state: WAIT, RESP, IDLE.
  task automatic test_back_to_back;
    int pulses = 0;
    rd_mem = 1'b1; adr = 6'd1;
    for (int i = 1; i <= 9; i++) begin
      step();
      if (i == 8) rd_mem = 1'b0;
      if (rdy1) pulses++;
      total++;
      if ({rdy1, busy1} !== {(i % 3) == 2, (i % 3) != 0})
        $display("[TB] FAIL b2b_step%0d: got rdy/busy %b want %b", i, {rdy1, busy1}, {(i % 3) == 2, (i % 3) != 0});
      else passed++;
      if (i >= 2) begin
        total++;
        if (dout1 !== 8'h5C) $display("[TB] FAIL b2b_data%0d: got %h want 5c", i, dout1);
        else passed++;
      end
    end
    total++;
    if (pulses != 3) $display("[TB] FAIL b2b_pulses: got %0d want 3", pulses);
    else passed++;
  endtask

  initial begin
    reset = 1'b1; rd_mem = 1'b0; wr_mem = 1'b0; pl_en = 1'b0;
    adr = '0; pl_adr = '0; data_in = '0; pl_data = '0;
    test_reset();
    preload(6'd5, 8'h4A);
    preload(6'd0, 8'h11);
    preload(6'd2, 8'h22);
    preload(6'd9, 8'h00);
    preload(6'd1, 8'h5C);
    test_read_ws1();
    test_write_read();
    test_ws0();
    test_error();
    test_reset_mid_access();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
